// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Define DCACHE_STATS_EN to add the hit_count_o / miss_count_o statistics counters.
module dcache_controller #(
    parameter int unsigned INDEX_W = 5,
    parameter int unsigned LINE_W  = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              req_i,
    input  logic              write_i,
    input  logic [31:0]       addr_i,
    input  logic [31:0]       wdata_i,
    output logic [31:0]       rdata_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic              mem_ack_i,
    input  logic [LINE_W-1:0] mem_rdata_i
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]       hit_count_o,
    output logic [31:0]       miss_count_o
`endif
);

    localparam int unsigned TAG_W = 32 - 5 - INDEX_W;
    localparam int unsigned LINES = 1 << INDEX_W;

    typedef enum logic [1:0] {StIdle, StWriteback, StAllocate, StRefill} state_e;

    state_e state_q, state_d;

    logic [LINES-1:0]  valid_q, dirty_q;
    logic [TAG_W-1:0]  tag_q  [LINES];
    logic [LINE_W-1:0] data_q [LINES];

    // Line address of the access that missed; keeps the fill target stable even if req_i drops.
    logic [26:0]        miss_line_q;
    logic [INDEX_W-1:0] m_idx;
    logic [TAG_W-1:0]   m_tag;

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    logic [2:0]         word_sel;
    logic [7:0]         word_base;
    logic               hit, miss_go, store_hit, wb_done, fill, stall;
    logic               unused_addr;

    assign idx         = addr_i[4+INDEX_W:5];
    assign tag         = addr_i[31:5+INDEX_W];
    assign word_sel    = addr_i[4:2];
    assign word_base   = {word_sel, 5'b0};
    assign unused_addr = ^addr_i[1:0];

    assign m_idx = miss_line_q[INDEX_W-1:0];
    assign m_tag = miss_line_q[26:INDEX_W];

    assign hit       = req_i & valid_q[idx] & (tag_q[idx] == tag);
    assign miss_go   = (state_q == StIdle) & req_i & ~hit;
    assign store_hit = (state_q == StIdle) & hit & write_i;
    assign wb_done   = (state_q == StWriteback) & mem_ack_i;
    assign fill      = (state_q == StAllocate) & mem_ack_i;

    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        rdata_o     = '0;
        mem_req_o   = 1'b0;
        mem_write_o = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        unique case (state_q)
            StIdle: begin
                if (hit && !write_i) begin
                    rdata_o = data_q[idx][word_base +: 32];
                end
                if (miss_go) begin
                    stall   = 1'b1;
                    state_d = (valid_q[idx] && dirty_q[idx]) ? StWriteback : StAllocate;
                end
            end
            StWriteback: begin
                stall       = 1'b1;
                mem_req_o   = 1'b1;
                mem_write_o = 1'b1;
                mem_addr_o  = {tag_q[m_idx], m_idx, 5'b0};
                mem_wdata_o = data_q[m_idx];
                if (mem_ack_i) begin
                    state_d = StAllocate;
                end
            end
            StAllocate: begin
                stall      = 1'b1;
                mem_req_o  = 1'b1;
                mem_addr_o = {m_tag, m_idx, 5'b0};
                if (mem_ack_i) begin
                    state_d = StRefill;
                end
            end
            StRefill: begin
                stall   = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // An IDLE miss raises stall combinationally, so it must be masked while reset is held.
    assign stall_o = stall & rst_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= StIdle;
            valid_q     <= '0;
            dirty_q     <= '0;
            miss_line_q <= '0;
        end else begin
            state_q <= state_d;
            if (miss_go) begin
                miss_line_q <= addr_i[31:5];
            end
            if (wb_done) begin
                dirty_q[m_idx] <= 1'b0;
            end
            if (fill) begin
                valid_q[m_idx] <= 1'b1;
                dirty_q[m_idx] <= 1'b0;
            end
            if (store_hit) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (fill) begin
            data_q[m_idx] <= mem_rdata_i;
            tag_q[m_idx]  <= m_tag;
        end else if (store_hit) begin
            data_q[idx][word_base +: 32] <= wdata_i;
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count_q, miss_count_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            if ((state_q == StIdle) && hit) begin
                hit_count_q <= hit_count_q + 32'd1;
            end
            if (miss_go) begin
                miss_count_q <= miss_count_q + 32'd1;
            end
        end
    end

    assign hit_count_o  = hit_count_q;
    assign miss_count_o = miss_count_q;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Directed self-checking bench for dcache_controller: cold fill, store hit, dirty and clean
// conflict misses, reset abort during ALLOCATE; statistics checks when DCACHE_STATS_EN is set.
module tb_dcache_controller;

    logic         clk_i;
    logic         rst_i;
    logic         req_i;
    logic         write_i;
    logic [31:0]  addr_i;
    logic [31:0]  wdata_i;
    logic [31:0]  rdata_o;
    logic         stall_o;
    logic         mem_req_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_wdata_o;
    logic         mem_ack_i;
    logic [255:0] mem_rdata_i;
`ifdef DCACHE_STATS_EN
    logic [31:0]  hit_count_o;
    logic [31:0]  miss_count_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    dcache_controller dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_i       (req_i),
        .write_i     (write_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .rdata_o     (rdata_o),
        .stall_o     (stall_o),
        .mem_req_o   (mem_req_o),
        .mem_write_o (mem_write_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i)
`ifdef DCACHE_STATS_EN
        ,
        .hit_count_o (hit_count_o),
        .miss_count_o(miss_count_o)
`endif
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for a memory request, check it, then ack after lat cycles with line.
    task automatic serve(input string tag, input logic exp_wr, input logic [31:0] exp_addr,
                         input logic [255:0] line, input int lat, output logic [255:0] wdata);
        int n = 0;
        #1;
        while (!mem_req_o && n < 20) begin
            @(negedge clk_i);
            #1;
            n++;
        end
        check({tag, "_req"}, mem_req_o, 1);
        check({tag, "_wr"}, mem_write_o, exp_wr);
        check({tag, "_addr"}, mem_addr_o, exp_addr);
        check({tag, "_stall"}, stall_o, 1);
        wdata = mem_wdata_o;
        repeat (lat - 1) @(negedge clk_i);
        mem_ack_i   = 1'b1;
        mem_rdata_i = line;
        @(negedge clk_i);
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
    endtask

    // Called at the negedge after the fill ack: one REFILL cycle, then the retried access hits.
    task automatic refill_then_hit(input string tag, input logic [31:0] exp_rdata);
        #1;
        check({tag, "_refill_stall"}, stall_o, 1);
        check({tag, "_refill_req"}, mem_req_o, 0);
        @(negedge clk_i);
        #1;
        check({tag, "_retry_stall"}, stall_o, 0);
        check({tag, "_retry_rdata"}, rdata_o, exp_rdata);
    endtask

    task automatic drive(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
        req_i   = 1'b1;
        write_i = wr;
        addr_i  = addr;
        wdata_i = wd;
    endtask

    logic [255:0] line_a, line_b, wd;

    initial begin
        line_a = {32'h8888_0007, 32'h8888_0006, 32'h8888_0005, 32'h8888_0004,
                  32'h8888_0003, 32'h8888_0002, 32'h1111_1111, 32'h1234_5678};
        line_b = {32'h4444_0007, 32'h4444_0006, 32'h4444_0005, 32'h4444_0004,
                  32'h4444_0003, 32'h4444_0002, 32'h4444_0001, 32'hCAFE_0440};
        rst_i       = 1'b0;
        mem_ack_i   = 1'b0;
        mem_rdata_i = '0;
        drive(1'b0, 32'h0000_0040, 32'h0);

        // Reset: outputs quiet even with a request presented.
        @(negedge clk_i);
        #1;
        check("rst_stall", stall_o, 0);
        check("rst_mem_req", mem_req_o, 0);
        check("rst_rdata", rdata_o, 0);
        check("rst_mem_addr", mem_addr_o, 0);
        check("rst_mem_wdata", mem_wdata_o, 0);
`ifdef DCACHE_STATS_EN
        check("rst_hit_cnt", hit_count_o, 0);
        check("rst_miss_cnt", miss_count_o, 0);
`endif

        // Cold load miss on 0x40, ack after 3 cycles.
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("cold_miss_stall", stall_o, 1);
        serve("cold", 1'b0, 32'h0000_0040, line_a, 3, wd);
        refill_then_hit("cold", 32'h1234_5678);

        // Store hit to 0x44, then load it back without memory traffic.
        @(negedge clk_i);
        drive(1'b1, 32'h0000_0044, 32'hDEAD_BEEF);
        #1;
        check("store_hit_stall", stall_o, 0);
        check("store_hit_mem_req", mem_req_o, 0);
        @(negedge clk_i);
        drive(1'b0, 32'h0000_0044, 32'h0);
        #1;
        check("load44_rdata", rdata_o, 32'hDEAD_BEEF);
        check("load44_stall", stall_o, 0);
        check("load44_mem_req", mem_req_o, 0);

        // Dirty conflict: writeback of 0x40 line, then fetch of 0x440.
        @(negedge clk_i);
        drive(1'b0, 32'h0000_0440, 32'h0);
        #1;
        check("conflict_stall", stall_o, 1);
        serve("wb", 1'b1, 32'h0000_0040, '0, 2, wd);
        check("wb_word1", wd[63:32], 32'hDEAD_BEEF);
        check("wb_word0", wd[31:0], 32'h1234_5678);
        serve("fill440", 1'b0, 32'h0000_0440, line_b, 1, wd);
        refill_then_hit("fill440", 32'hCAFE_0440);

        // Clean conflict: the first request must already be the read.
        @(negedge clk_i);
        drive(1'b0, 32'h0000_0040, 32'h0);
        serve("clean", 1'b0, 32'h0000_0040, line_a, 2, wd);
        refill_then_hit("clean", 32'h1234_5678);

        // Reset while in ALLOCATE for 0x840 aborts the fill.
        @(negedge clk_i);
        drive(1'b0, 32'h0000_0840, 32'h0);
        @(negedge clk_i);
        #1;
        check("alloc840_req", mem_req_o, 1);
        check("alloc840_wr", mem_write_o, 0);
`ifdef DCACHE_STATS_EN
        check("pre_rst_hit_cnt", hit_count_o, 5);
        check("pre_rst_miss_cnt", miss_count_o, 4);
`endif
        rst_i = 1'b0;
        #1;
        check("abort_mem_req", mem_req_o, 0);
        check("abort_stall", stall_o, 0);
        @(negedge clk_i);
        drive(1'b0, 32'h0000_0040, 32'h0);
        rst_i = 1'b1;
        #1;
        check("reload_miss_stall", stall_o, 1);
        serve("reload", 1'b0, 32'h0000_0040, line_a, 1, wd);
        refill_then_hit("reload", 32'h1234_5678);

        // Idle with no request: stray ack is ignored.
        @(negedge clk_i);
        req_i     = 1'b0;
        mem_ack_i = 1'b1;
        #1;
        check("idle_rdata", rdata_o, 0);
        check("idle_stall", stall_o, 0);
        @(negedge clk_i);
        mem_ack_i = 1'b0;
        #1;
        check("stray_ack_req", mem_req_o, 0);
        check("stray_ack_stall", stall_o, 0);
`ifdef DCACHE_STATS_EN
        check("end_hit_cnt", hit_count_o, 1);
        check("end_miss_cnt", miss_count_o, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
